// File: rtl/kw_match_engine.sv
// kw_match_engine: run-time keyword table with a 2-stage token compare.
// Define KWM_RUN_EN to add the consecutive-hit run detector on out_run.
module kw_match_engine #(
    parameter int         DW       = 8,
    parameter int         NK       = 8,
    parameter int         IW       = 3,
    parameter int         CW       = 16,
    parameter logic [7:0] CODE_HIT = 8'd127,
    parameter int         KEY_A    = 7,
    parameter logic [7:0] CODE_A   = 8'd63,
    parameter int         KEY_B    = 9,
    parameter logic [7:0] CODE_B   = 8'd191,
    parameter int         RUN_LEN  = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          kw_we,
    input  logic [IW-1:0] kw_addr,
    input  logic [DW-1:0] kw_data,
    input  logic          kw_clr,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    output logic [7:0]    out_code,
    output logic          out_hit,
    output logic [IW-1:0] out_idx,
    output logic [CW-1:0] hit_cnt,
    output logic          out_run
);

    logic [NK-1:0][DW-1:0] key_q;
    logic [NK-1:0]         vld_q;
    logic [NK-1:0]         m_d, m_q;
    logic                  a_q, b_q, v1_q;
    logic [IW-1:0]         idx_d;
    logic                  hit_d;
    logic [7:0]            code_d;
    logic                  out_valid_q, out_hit_q;
    logic [7:0]            out_code_q;
    logic [IW-1:0]         out_idx_q;
    logic [CW-1:0]         cnt_q;

    // Addresses >= NK match no entry, so such writes fall away.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            key_q <= '0;
            vld_q <= '0;
        end else if (kw_clr) begin
            vld_q <= '0;
        end else if (kw_we) begin
            for (int i = 0; i < NK; i++) begin
                if (kw_addr == IW'(i)) begin
                    key_q[i] <= kw_data;
                    vld_q[i] <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        m_d = '0;
        for (int i = 0; i < NK; i++)
            m_d[i] = vld_q[i] && (key_q[i] == in_data);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_q  <= '0;
            a_q  <= 1'b0;
            b_q  <= 1'b0;
            v1_q <= 1'b0;
        end else begin
            v1_q <= in_valid;
            if (in_valid) begin
                m_q <= m_d;
                a_q <= (in_data == DW'(KEY_A));
                b_q <= (in_data == DW'(KEY_B));
            end
        end
    end

    always_comb begin
        idx_d = '0;
        for (int i = NK - 1; i >= 0; i--)
            if (m_q[i]) idx_d = IW'(i);
    end

    assign hit_d = |m_q;

    always_comb begin
        code_d = 8'd0;
        if (hit_d)    code_d = CODE_HIT;
        else if (a_q) code_d = CODE_A;
        else if (b_q) code_d = CODE_B;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid_q <= 1'b0;
            out_hit_q   <= 1'b0;
            out_code_q  <= '0;
            out_idx_q   <= '0;
            cnt_q       <= '0;
        end else begin
            out_valid_q <= v1_q;
            if (v1_q) begin
                out_hit_q  <= hit_d;
                out_code_q <= code_d;
                out_idx_q  <= idx_d;
                if (hit_d && cnt_q != '1)
                    cnt_q <= cnt_q + CW'(1);
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_hit   = out_hit_q;
    assign out_code  = out_code_q;
    assign out_idx   = out_idx_q;
    assign hit_cnt   = cnt_q;

`ifdef KWM_RUN_EN
    localparam int RW = $clog2(RUN_LEN + 1);

    typedef enum logic {IDLE, COUNT} run_st_e;

    run_st_e       st_q;
    logic [RW-1:0] run_q;
    logic [RW-1:0] run_nx;
    logic          run_out_q;

    assign run_nx = (st_q == IDLE) ? RW'(1) : run_q + RW'(1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st_q      <= IDLE;
            run_q     <= '0;
            run_out_q <= 1'b0;
        end else begin
            run_out_q <= 1'b0;
            if (v1_q) begin
                if (!hit_d) begin
                    st_q  <= IDLE;
                    run_q <= '0;
                end else if (run_nx == RW'(RUN_LEN)) begin
                    run_out_q <= 1'b1;
                    st_q      <= IDLE;
                    run_q     <= '0;
                end else begin
                    st_q  <= COUNT;
                    run_q <= run_nx;
                end
            end
        end
    end

    assign out_run = run_out_q;
`else
    logic unused_run;
    assign unused_run = |RUN_LEN;
    assign out_run    = 1'b0;
`endif

endmodule
